// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single-write-port register file: ALU and MEM each own a
// one-entry buffer, a round-robin arbiter feeds a registered write stage.
module regfile_wb_arbiter #(
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int NREG = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          alu_req,
   input  logic [AW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   output logic          alu_ack,
   input  logic          mem_req,
   input  logic [AW-1:0] mem_rd,
   input  logic [DW-1:0] mem_data,
   output logic          mem_ack,
   output logic          rf_we,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_data,
   input  logic [AW-1:0] chk_reg1,
   input  logic [AW-1:0] chk_reg2,
   output logic          hazard1,
   output logic          hazard2
);

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   logic            aluValid_q, aluValid_d;
   logic [AW-1:0]   aluRd_q, aluRd_d;
   logic [DW-1:0]   aluData_q, aluData_d;
   logic            memValid_q, memValid_d;
   logic [AW-1:0]   memRd_q, memRd_d;
   logic [DW-1:0]   memData_q, memData_d;
   logic [NREG-1:0] pending_q, pending_d;
   src_e            rrLast_q, rrLast_d;
   logic            rfWe_q, rfWe_d;
   logic [AW-1:0]   rfAddr_q, rfAddr_d;
   logic [DW-1:0]   rfData_q, rfData_d;

   logic grantAlu, grantMem;
   logic aluAck, memAck;
   logic aluLoad, memLoad;

   // Round-robin only matters when both buffers hold an entry.
   always_comb begin
      grantAlu = aluValid_q & (~memValid_q | (rrLast_q == SRC_MEM));
      grantMem = memValid_q & (~aluValid_q | (rrLast_q == SRC_ALU));
   end

   // A same-rd collision goes to MEM; r0 collisions are harmless no-ops so ALU is not held back.
   always_comb begin
      memAck  = ~reset & mem_req & ~pending_q[mem_rd] & (~memValid_q | grantMem);
      aluAck  = ~reset & alu_req & ~pending_q[alu_rd] & (~aluValid_q | grantAlu)
                & ~(memAck & (mem_rd == alu_rd) & (alu_rd != '0));
      aluLoad = aluAck & (alu_rd != '0);
      memLoad = memAck & (mem_rd != '0);
   end

   always_comb begin
      aluValid_d = aluValid_q & ~grantAlu;
      aluRd_d    = aluRd_q;
      aluData_d  = aluData_q;
      memValid_d = memValid_q & ~grantMem;
      memRd_d    = memRd_q;
      memData_d  = memData_q;
      if (aluLoad) begin
         aluValid_d = 1'b1;
         aluRd_d    = alu_rd;
         aluData_d  = alu_data;
      end
      if (memLoad) begin
         memValid_d = 1'b1;
         memRd_d    = mem_rd;
         memData_d  = mem_data;
      end
   end

   // The bit being committed is pending, so it can never be re-set in the same edge.
   always_comb begin
      pending_d = pending_q;
      if (rfWe_q) pending_d[rfAddr_q] = 1'b0;
      if (aluLoad) pending_d[alu_rd] = 1'b1;
      if (memLoad) pending_d[mem_rd] = 1'b1;
   end

   always_comb begin
      rfWe_d   = grantAlu | grantMem;
      rfAddr_d = rfAddr_q;
      rfData_d = rfData_q;
      rrLast_d = rrLast_q;
      if (grantAlu) begin
         rfAddr_d = aluRd_q;
         rfData_d = aluData_q;
         rrLast_d = SRC_ALU;
      end else if (grantMem) begin
         rfAddr_d = memRd_q;
         rfData_d = memData_q;
         rrLast_d = SRC_MEM;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aluValid_q <= 1'b0;
         aluRd_q    <= '0;
         aluData_q  <= '0;
         memValid_q <= 1'b0;
         memRd_q    <= '0;
         memData_q  <= '0;
         pending_q  <= '0;
         rrLast_q   <= SRC_MEM;
         rfWe_q     <= 1'b0;
         rfAddr_q   <= '0;
         rfData_q   <= '0;
      end else begin
         aluValid_q <= aluValid_d;
         aluRd_q    <= aluRd_d;
         aluData_q  <= aluData_d;
         memValid_q <= memValid_d;
         memRd_q    <= memRd_d;
         memData_q  <= memData_d;
         pending_q  <= pending_d;
         rrLast_q   <= rrLast_d;
         rfWe_q     <= rfWe_d;
         rfAddr_q   <= rfAddr_d;
         rfData_q   <= rfData_d;
      end
   end

   assign alu_ack = aluAck;
   assign mem_ack = memAck;
   assign rf_we   = rfWe_q;
   assign rf_addr = rfAddr_q;
   assign rf_data = rfData_q;
   assign hazard1 = pending_q[chk_reg1] & (chk_reg1 != '0);
   assign hazard2 = pending_q[chk_reg2] & (chk_reg2 != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus hand-written
// streaming and asynchronous-reset sequences.
module tb_regfile_wb_arbiter;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NVEC = 31;

   logic          clk;
   logic          reset;
   logic          alu_req;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ack;
   logic          mem_req;
   logic [AW-1:0] mem_rd;
   logic [DW-1:0] mem_data;
   logic          mem_ack;
   logic          rf_we;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;
   logic [AW-1:0] chk_reg1;
   logic [AW-1:0] chk_reg2;
   logic          hazard1;
   logic          hazard2;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter #(.AW(AW), .DW(DW), .NREG(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .alu_req  (alu_req),
      .alu_rd   (alu_rd),
      .alu_data (alu_data),
      .alu_ack  (alu_ack),
      .mem_req  (mem_req),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .mem_ack  (mem_ack),
      .rf_we    (rf_we),
      .rf_addr  (rf_addr),
      .rf_data  (rf_data),
      .chk_reg1 (chk_reg1),
      .chk_reg2 (chk_reg2),
      .hazard1  (hazard1),
      .hazard2  (hazard2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          aReq;
      logic [AW-1:0] aRd;
      logic [DW-1:0] aData;
      logic          mReq;
      logic [AW-1:0] mRd;
      logic [DW-1:0] mData;
      logic [AW-1:0] c1;
      logic [AW-1:0] c2;
      logic          eAAck;
      logic          eMAck;
      logic          eWe;
      logic [AW-1:0] eAddr;
      logic [DW-1:0] eData;
      logic          eH1;
      logic          eH2;
   } vecT;

   vecT vecs [NVEC];

   function automatic vecT mkVec(input logic aReq, input logic [AW-1:0] aRd, input logic [DW-1:0] aData,
                                 input logic mReq, input logic [AW-1:0] mRd, input logic [DW-1:0] mData,
                                 input logic [AW-1:0] c1, input logic [AW-1:0] c2,
                                 input logic eAAck, input logic eMAck, input logic eWe,
                                 input logic [AW-1:0] eAddr, input logic [DW-1:0] eData,
                                 input logic eH1, input logic eH2);
      vecT v;
      v.aReq = aReq;   v.aRd = aRd;     v.aData = aData;
      v.mReq = mReq;   v.mRd = mRd;     v.mData = mData;
      v.c1 = c1;       v.c2 = c2;
      v.eAAck = eAAck; v.eMAck = eMAck; v.eWe = eWe;
      v.eAddr = eAddr; v.eData = eData;
      v.eH1 = eH1;     v.eH2 = eH2;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vecT v);
      alu_req  = v.aReq;
      alu_rd   = v.aRd;
      alu_data = v.aData;
      mem_req  = v.mReq;
      mem_rd   = v.mRd;
      mem_data = v.mData;
      chk_reg1 = v.c1;
      chk_reg2 = v.c2;
   endtask

   task automatic checkOutput(input int idx, input vecT v);
      checkVal($sformatf("v%0d alu_ack", idx), {31'd0, alu_ack}, {31'd0, v.eAAck});
      checkVal($sformatf("v%0d mem_ack", idx), {31'd0, mem_ack}, {31'd0, v.eMAck});
      checkVal($sformatf("v%0d rf_we", idx),   {31'd0, rf_we},   {31'd0, v.eWe});
      checkVal($sformatf("v%0d rf_addr", idx), {27'd0, rf_addr}, {27'd0, v.eAddr});
      checkVal($sformatf("v%0d rf_data", idx), rf_data,          v.eData);
      checkVal($sformatf("v%0d hazard1", idx), {31'd0, hazard1}, {31'd0, v.eH1});
      checkVal($sformatf("v%0d hazard2", idx), {31'd0, hazard2}, {31'd0, v.eH2});
   endtask

   task automatic idleInputs();
      alu_req  = 1'b0;
      alu_rd   = '0;
      alu_data = '0;
      mem_req  = 1'b0;
      mem_rd   = '0;
      mem_data = '0;
   endtask

   initial begin
      // aReq aRd aData | mReq mRd mData | c1 c2 | aAck mAck we addr data | h1 h2
      vecs[0]  = mkVec(0, 0, 0,            0, 0, 0,       5, 3, 0, 0, 0, 0, 0,            0, 0);
      vecs[1]  = mkVec(1, 3, 'h33,         1, 4, 'h44,    3, 4, 1, 1, 0, 0, 0,            0, 0);
      vecs[2]  = mkVec(0, 0, 0,            0, 0, 0,       3, 4, 0, 0, 0, 0, 0,            1, 1);
      vecs[3]  = mkVec(0, 0, 0,            0, 0, 0,       3, 4, 0, 0, 1, 3, 'h33,         1, 1);
      vecs[4]  = mkVec(0, 0, 0,            0, 0, 0,       3, 4, 0, 0, 1, 4, 'h44,         0, 1);
      vecs[5]  = mkVec(1, 5, 'hDEADBEEF,   0, 0, 0,       5, 4, 1, 0, 0, 4, 'h44,         0, 0);
      vecs[6]  = mkVec(0, 0, 0,            0, 0, 0,       5, 4, 0, 0, 0, 4, 'h44,         1, 0);
      vecs[7]  = mkVec(0, 0, 0,            0, 0, 0,       5, 4, 0, 0, 1, 5, 'hDEADBEEF,   1, 0);
      vecs[8]  = mkVec(0, 0, 0,            0, 0, 0,       5, 4, 0, 0, 0, 5, 'hDEADBEEF,   0, 0);
      vecs[9]  = mkVec(1, 3, 'hA3,         1, 4, 'hB4,    3, 4, 1, 1, 0, 5, 'hDEADBEEF,   0, 0);
      vecs[10] = mkVec(0, 0, 0,            0, 0, 0,       3, 4, 0, 0, 0, 5, 'hDEADBEEF,   1, 1);
      vecs[11] = mkVec(0, 0, 0,            0, 0, 0,       3, 4, 0, 0, 1, 4, 'hB4,         1, 1);
      vecs[12] = mkVec(0, 0, 0,            0, 0, 0,       3, 4, 0, 0, 1, 3, 'hA3,         1, 0);
      vecs[13] = mkVec(0, 0, 0,            0, 0, 0,       3, 4, 0, 0, 0, 3, 'hA3,         0, 0);
      vecs[14] = mkVec(1, 7, 'h77,         0, 0, 0,       7, 0, 1, 0, 0, 3, 'hA3,         0, 0);
      vecs[15] = mkVec(0, 0, 0,            1, 7, 'h7E,    7, 0, 0, 0, 0, 3, 'hA3,         1, 0);
      vecs[16] = mkVec(0, 0, 0,            1, 7, 'h7E,    7, 0, 0, 0, 1, 7, 'h77,         1, 0);
      vecs[17] = mkVec(0, 0, 0,            1, 7, 'h7E,    7, 0, 0, 1, 0, 7, 'h77,         0, 0);
      vecs[18] = mkVec(0, 0, 0,            0, 0, 0,       7, 0, 0, 0, 0, 7, 'h77,         1, 0);
      vecs[19] = mkVec(0, 0, 0,            0, 0, 0,       7, 0, 0, 0, 1, 7, 'h7E,         1, 0);
      vecs[20] = mkVec(0, 0, 0,            0, 0, 0,       7, 0, 0, 0, 0, 7, 'h7E,         0, 0);
      vecs[21] = mkVec(1, 9, 'h91,         1, 9, 'h92,    9, 0, 0, 1, 0, 7, 'h7E,         0, 0);
      vecs[22] = mkVec(1, 9, 'h91,         0, 0, 0,       9, 0, 0, 0, 0, 7, 'h7E,         1, 0);
      vecs[23] = mkVec(1, 9, 'h91,         0, 0, 0,       9, 0, 0, 0, 1, 9, 'h92,         1, 0);
      vecs[24] = mkVec(1, 9, 'h91,         0, 0, 0,       9, 0, 1, 0, 0, 9, 'h92,         0, 0);
      vecs[25] = mkVec(0, 0, 0,            0, 0, 0,       9, 0, 0, 0, 0, 9, 'h92,         1, 0);
      vecs[26] = mkVec(0, 0, 0,            0, 0, 0,       9, 0, 0, 0, 1, 9, 'h91,         1, 0);
      vecs[27] = mkVec(0, 0, 0,            0, 0, 0,       9, 0, 0, 0, 0, 9, 'h91,         0, 0);
      vecs[28] = mkVec(1, 0, 'h1234,       0, 0, 0,       0, 9, 1, 0, 0, 9, 'h91,         0, 0);
      vecs[29] = mkVec(0, 0, 0,            0, 0, 0,       0, 9, 0, 0, 0, 9, 'h91,         0, 0);
      vecs[30] = mkVec(0, 0, 0,            0, 0, 0,       0, 9, 0, 0, 0, 9, 'h91,         0, 0);

      reset = 1'b1;
      idleInputs();
      chk_reg1 = '0;
      chk_reg2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         @(posedge clk);
         #1;
         applyStimulus(vecs[i]);
         #1;
         checkOutput(i, vecs[i]);
      end

      // ALU streams rd=1..8 on consecutive cycles; writes trail by two cycles.
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         idleInputs();
         chk_reg1 = '0;
         chk_reg2 = '0;
         if (i < 8) begin
            alu_req  = 1'b1;
            alu_rd   = AW'(i + 1);
            alu_data = 32'h100 + 32'(i);
         end
         #1;
         checkVal($sformatf("stream%0d alu_ack", i), {31'd0, alu_ack}, {31'd0, (i < 8)});
         checkVal($sformatf("stream%0d rf_we", i), {31'd0, rf_we}, {31'd0, (i >= 2 && i < 10)});
         if (i >= 2 && i < 10) begin
            checkVal($sformatf("stream%0d rf_addr", i), {27'd0, rf_addr}, 32'(i - 1));
            checkVal($sformatf("stream%0d rf_data", i), rf_data, 32'h100 + 32'(i - 2));
         end
      end

      // Fill both buffers and the write stage, then hit reset between edges.
      @(posedge clk);
      #1;
      alu_req = 1'b1; alu_rd = 5'd11; alu_data = 'hB1;
      mem_req = 1'b1; mem_rd = 5'd12; mem_data = 'hC2;
      #1;
      checkVal("rst setup alu_ack", {31'd0, alu_ack}, 32'd1);
      checkVal("rst setup mem_ack", {31'd0, mem_ack}, 32'd1);
      @(posedge clk);
      #1;
      idleInputs();
      mem_req = 1'b1; mem_rd = 5'd14; mem_data = 'hE4;
      #1;
      checkVal("rst refill mem_ack", {31'd0, mem_ack}, 32'd1);
      checkVal("rst refill alu_ack", {31'd0, alu_ack}, 32'd0);
      @(posedge clk);
      #1;
      idleInputs();
      alu_req = 1'b1; alu_rd = 5'd15; alu_data = 'hF5;
      chk_reg1 = 5'd11;
      chk_reg2 = 5'd14;
      #1;
      checkVal("pre-rst rf_we", {31'd0, rf_we}, 32'd1);
      checkVal("pre-rst rf_addr", {27'd0, rf_addr}, 32'd12);
      checkVal("pre-rst rf_data", rf_data, 32'hC2);
      checkVal("pre-rst hazard1", {31'd0, hazard1}, 32'd1);
      checkVal("pre-rst hazard2", {31'd0, hazard2}, 32'd1);
      checkVal("pre-rst alu_ack", {31'd0, alu_ack}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      checkVal("rst rf_we", {31'd0, rf_we}, 32'd0);
      checkVal("rst rf_addr", {27'd0, rf_addr}, 32'd0);
      checkVal("rst rf_data", rf_data, 32'd0);
      checkVal("rst alu_ack", {31'd0, alu_ack}, 32'd0);
      checkVal("rst mem_ack", {31'd0, mem_ack}, 32'd0);
      checkVal("rst hazard1", {31'd0, hazard1}, 32'd0);
      checkVal("rst hazard2", {31'd0, hazard2}, 32'd0);
      idleInputs();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #2;
         checkVal($sformatf("post-rst%0d rf_we", i), {31'd0, rf_we}, 32'd0);
         checkVal($sformatf("post-rst%0d hazard1", i), {31'd0, hazard1}, 32'd0);
         checkVal($sformatf("post-rst%0d hazard2", i), {31'd0, hazard2}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
